// File: rtl/vliw_hazard_ctrl_if.sv
// Control-bundle interface between the ID/EX pipeline stages and the hazard sequencer.
interface vliw_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 3,
  parameter int unsigned CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_alu_rn;
  logic [REG_AW-1:0] id_alu_rm;
  logic              id_alu_uses_rm;
  logic [REG_AW-1:0] id_mem_rn;
  logic [REG_AW-1:0] id_mem_rd;
  logic              id_mem_is_store;
  logic              ex_valid;
  logic              ex_mem_is_load;
  logic [REG_AW-1:0] ex_mem_rd;
  logic              ex_mem_access;
  logic              mem_ready;
  logic              branch_taken;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_write;
  logic              idex_bubble;
  logic [1:0]        state;
  logic [CNT_W-1:0]  stall_count;
  logic              mem_timeout;

  // Pipeline side: drives stage status, consumes the control enables.
  modport master (
    output id_valid, id_alu_rn, id_alu_rm, id_alu_uses_rm, id_mem_rn, id_mem_rd,
           id_mem_is_store, ex_valid, ex_mem_is_load, ex_mem_rd, ex_mem_access,
           mem_ready, branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, state,
           stall_count, mem_timeout
  );

  // Sequencer side.
  modport slave (
    input  id_valid, id_alu_rn, id_alu_rm, id_alu_uses_rm, id_mem_rn, id_mem_rd,
           id_mem_is_store, ex_valid, ex_mem_is_load, ex_mem_rd, ex_mem_access,
           mem_ready, branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, state,
           stall_count, mem_timeout
  );
endinterface

// File: rtl/vliw_hazard_ctrl.sv
// Pipeline sequencer for the two-slot VLIW core: load-use stall, branch squash,
// memory-wait freeze, stall-cycle counter and sticky memory-timeout flag.
module vliw_hazard_ctrl #(
  parameter int unsigned REG_AW      = 3,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input logic                clk,
  input logic                reset,
  vliw_hazard_ctrl_if.slave  hz
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLoadUse = 2'd1,
    StMemWait = 2'd2,
    StFlush   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             timeout_q, timeout_d;

  logic memwait, reg_match, hazard;
  logic pc_wr, ifid_wr, ifid_fl, idex_wr, idex_bub;

  // Hazard detection; in FLUSH the ID bundle is already squashed so it cannot conflict.
  always_comb begin
    memwait   = hz.ex_valid & hz.ex_mem_access & ~hz.mem_ready;
    reg_match = (hz.ex_mem_rd == hz.id_alu_rn)
              | (hz.id_alu_uses_rm & (hz.ex_mem_rd == hz.id_alu_rm))
              | (hz.ex_mem_rd == hz.id_mem_rn)
              | (hz.id_mem_is_store & (hz.ex_mem_rd == hz.id_mem_rd));
    hazard    = hz.ex_valid & hz.ex_mem_is_load & hz.id_valid & reg_match
              & (state_q != StFlush);
  end

  // Priority table: memwait > branch_taken > hazard > normal, identical in every state.
  always_comb begin
    pc_wr    = 1'b1;
    ifid_wr  = 1'b1;
    ifid_fl  = 1'b0;
    idex_wr  = 1'b1;
    idex_bub = 1'b0;
    state_d  = StRun;
    if (memwait) begin
      pc_wr   = 1'b0;
      ifid_wr = 1'b0;
      idex_wr = 1'b0;
      state_d = StMemWait;
    end else if (hz.branch_taken) begin
      ifid_fl  = 1'b1;
      idex_bub = 1'b1;
      state_d  = StFlush;
    end else if (hazard) begin
      pc_wr    = 1'b0;
      ifid_wr  = 1'b0;
      idex_bub = 1'b1;
      state_d  = StLoadUse;
    end
  end

  // Counter next-state: saturating stall count, consecutive MEM_WAIT cycle count.
  always_comb begin
    stall_d   = stall_q;
    wait_d    = '0;
    timeout_d = timeout_q;
    if (!pc_wr && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (state_q == StMemWait) begin
      wait_d = (wait_q != WaitMax) ? wait_q + WaitW'(1) : wait_q;
      if (wait_d == WaitMax) begin
        timeout_d = 1'b1;
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StRun;
      wait_q    <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  // While reset is held the front end is frozen and both NOP injections are forced.
  always_comb begin
    hz.pc_write    = reset & pc_wr;
    hz.ifid_write  = reset & ifid_wr;
    hz.idex_write  = reset & idex_wr;
    hz.ifid_flush  = ~reset | ifid_fl;
    hz.idex_bubble = ~reset | idex_bub;
    hz.state       = state_q;
    hz.stall_count = stall_q;
    hz.mem_timeout = timeout_q;
  end

endmodule

// File: doc/vliw_hazard_ctrl.md
Name: vliw_hazard_ctrl

Overview:
- Pipeline sequencer for the two-slot VLIW core (ALU slot + MEM slot per 32-bit bundle).
- Drives the write-enables of the PC and the IF/ID and ID/EX pipeline registers.
- Inserts a one-bubble stall for load-use hazards, squashes wrong-path bundles on taken branches, and freezes the front end while a MEM-slot access waits on memory.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

Parameters:
REG_AW, 3, register-specifier width (8 architectural registers)
CNT_W, 16, width of stall_count
MEM_TIMEOUT, 15, consecutive MEM_WAIT cycles after which mem_timeout sets

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID stage holds a real bundle
id_alu_rn  in  REG_AW  ALU-slot source rn in ID
id_alu_rm  in  REG_AW  ALU-slot source rm in ID
id_alu_uses_rm  in  1  ALU op reads rm (0 = imm3 form)
id_mem_rn  in  REG_AW  MEM-slot base register in ID
id_mem_rd  in  REG_AW  MEM-slot rd in ID
id_mem_is_store  in  1  MEM op in ID is a store (rd is read)
ex_valid  in  1  EX stage holds a real bundle
ex_mem_is_load  in  1  MEM op in EX is a load
ex_mem_rd  in  REG_AW  load destination in EX
ex_mem_access  in  1  MEM op in EX accesses data memory
mem_ready  in  1  data memory completes the access this cycle
branch_taken  in  1  branch resolved taken in EX
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID regWrite
ifid_flush  out  1  IF/ID loads a NOP bundle
idex_write  out  1  ID/EX regWrite
idex_bubble  out  1  ID/EX loads a NOP bundle (p2 valid = 0)
state  out  2  FSM state: 0 RUN, 1 LOAD_USE, 2 MEM_WAIT, 3 FLUSH
stall_count  out  CNT_W  cycles with pc_write = 0
mem_timeout  out  1  sticky memory-timeout error flag

Behaviour:
- Reset low, asynchronous:
  - state = RUN, stall_count = 0, mem_timeout = 0, wait counter = 0.
  - pc_write, ifid_write and idex_write are 0.
  - ifid_flush and idex_bubble are 1.
- Control outputs are combinational from state and inputs, for the current cycle. state and the counters update on the rising edge of clk.
- Conditions:
  - memwait = ex_valid & ex_mem_access & !mem_ready.
  - hazard = ex_valid & ex_mem_is_load & id_valid & (ex_mem_rd matches id_alu_rn, OR id_alu_rm when id_alu_uses_rm, OR id_mem_rn, OR id_mem_rd when id_mem_is_store).
  - Register r0 is not special: a match on 0 is a hazard.
- Priority: memwait > branch_taken > hazard > normal.
  - memwait: all three enables 0, no flush or bubble. Next state MEM_WAIT.
  - branch_taken: pc_write = ifid_write = idex_write = 1, ifid_flush = 1, idex_bubble = 1. Next state FLUSH.
  - hazard: pc_write = 0, ifid_write = 0, idex_write = 1, idex_bubble = 1. Next state LOAD_USE.
  - normal: all enables 1, flush and bubble 0. Next state RUN.
- MEM_WAIT:
  - The same rules apply each cycle; the FSM stays while memwait holds.
  - branch_taken and the ex_* inputs are held by the frozen ID/EX register and are acted on in the cycle mem_ready = 1.
- LOAD_USE and FLUSH each last exactly one cycle. Transitions out of them use the same priority table.
  - In FLUSH, hazard is ignored (ID holds a squashed bundle).
  - In LOAD_USE, hazard is re-evaluated normally (it is normally false because EX holds the bubble).
- stall_count increments on every clock edge where pc_write = 0, and saturates at 2^CNT_W - 1.
- Memory timeout:
  - The wait counter counts consecutive cycles in MEM_WAIT and clears on leaving it.
  - When it reaches MEM_TIMEOUT, mem_timeout sets and stays set until reset.
  - The freeze continues; there is no forced recovery.
- Reset asserted mid-stall: state and counters clear immediately. The first cycle after reset release behaves as RUN.

Test Plan:
- No hazards, 10 back-to-back valid bundles -> all enables 1 every cycle, state 0, stall_count stays 0.
- EX load r3, ID ALU reads rn = 3 -> one cycle with pc_write = 0, ifid_write = 0, idex_bubble = 1; state 1 for one cycle, then 0; stall_count = 1. Repeat with id_alu_rm = 3 and id_alu_uses_rm = 0 -> no stall.
- ex_mem_access with mem_ready low for 4 cycles -> enables 0 for 4 cycles, state 2, stall_count = 4, then normal operation resumes in the mem_ready cycle.
- branch_taken concurrent with a load-use match -> ifid_flush = 1, idex_bubble = 1, pc_write = 1, state 3, no LOAD_USE. Same inputs with memwait -> freeze first, flush in the mem_ready cycle.
- mem_ready held low for 20 cycles -> mem_timeout rises after the 15th MEM_WAIT cycle and remains 1 after mem_ready; only reset clears it.
- reset pulsed low during MEM_WAIT -> state 0, stall_count 0, mem_timeout 0 asynchronously; enables 0 while reset is low.
